// File: rtl/geo_pixel_rmw.sv
// geo_pixel_rmw: read-modify-write pixel engine on the mux geometry port.
// Define GEO_PIXEL_RMW_COALESCE_EN to hold a dirty word and merge same-address pixels.
module geo_pixel_rmw #(
  parameter int RD_TIMEOUT = 15,
  parameter int FLUSH_IDLE = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [19:0] cmd_addr,
  input  logic [3:0]  cmd_bit,
  input  logic [1:0]  cmd_bpp,
  input  logic [7:0]  cmd_color,
  input  logic        cmd_flush,
  output logic        geo_rd_req_a,
  output logic        geo_wr_ena,
  output logic [19:0] address_geo,
  output logic [15:0] data_in_geo,
  input  logic        geo_rd_rdy_a,
  input  logic [15:0] data_out_geo,
  input  logic        geo_port_full,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    HOLD
  } state_t;

  localparam logic [3:0] TO_LAST = 4'(RD_TIMEOUT - 1);

  state_t      st;
  state_t      nxt;
  logic [3:0]  to_cnt;
  logic [19:0] c_addr;
  logic [3:0]  c_bit;
  logic [1:0]  c_bpp;
  logic [7:0]  c_color;
  logic        pend;
  logic        to_hit;
  logic        rd_req;
  logic        wr_req;
  logic        ready;

  // Pixel field is aligned down to its own width inside the word.
  function automatic logic [15:0] merge(
    input logic [15:0] w,
    input logic [3:0]  b,
    input logic [1:0]  bpp,
    input logic [7:0]  c
  );
    logic [3:0]  width;
    logic [3:0]  s;
    logic [15:0] lo;
    logic [15:0] m;
    logic [15:0] v;
    width = 4'd1 << bpp;
    s     = b & ~(width - 4'd1);
    lo    = (16'd1 << width) - 16'd1;
    m     = lo << s;
    v     = ({8'd0, c} & lo) << s;
    return (w & ~m) | v;
  endfunction

  assign to_hit = (to_cnt == TO_LAST);

`ifdef GEO_PIXEL_RMW_COALESCE_EN
  localparam logic [7:0] IDLE_LAST = 8'(FLUSH_IDLE - 1);

  logic [7:0] idle_cnt;
  logic       same_addr;
  logic       idle_hit;

  assign same_addr = (cmd_addr == address_geo);
  assign idle_hit  = (idle_cnt == IDLE_LAST);
`else
  logic [8:0] unused_cfg;

  assign unused_cfg = {cmd_flush, 8'(FLUSH_IDLE)};
`endif

  always_comb begin
    nxt    = st;
    rd_req = 1'b0;
    wr_req = 1'b0;
    ready  = 1'b0;
    unique case (st)
      IDLE: begin
        ready = 1'b1;
        if (cmd_valid) nxt = RD;
      end
      RD: begin
        if (!geo_port_full) begin
          rd_req = 1'b1;
          nxt    = WAIT;
        end
      end
      WAIT: begin
        if (geo_rd_rdy_a) begin
`ifdef GEO_PIXEL_RMW_COALESCE_EN
          nxt = HOLD;
`else
          nxt = WR;
`endif
        end else if (to_hit) begin
          nxt = IDLE;
        end
      end
      WR: begin
        if (!geo_port_full) begin
          wr_req = 1'b1;
          nxt    = pend ? RD : IDLE;
        end
      end
`ifdef GEO_PIXEL_RMW_COALESCE_EN
      HOLD: begin
        ready = 1'b1;
        if (cmd_valid) begin
          if (!same_addr || cmd_flush) nxt = WR;
        end else if (idle_hit) begin
          nxt = WR;
        end
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st          <= IDLE;
      to_cnt      <= 4'd0;
      c_addr      <= 20'd0;
      c_bit       <= 4'd0;
      c_bpp       <= 2'd0;
      c_color     <= 8'd0;
      pend        <= 1'b0;
      address_geo <= 20'd0;
      data_in_geo <= 16'd0;
      err_timeout <= 1'b0;
`ifdef GEO_PIXEL_RMW_COALESCE_EN
      idle_cnt    <= 8'd0;
`endif
    end else begin
      st <= nxt;
      unique case (st)
        IDLE: begin
          if (cmd_valid) begin
            c_addr      <= cmd_addr;
            c_bit       <= cmd_bit;
            c_bpp       <= cmd_bpp;
            c_color     <= cmd_color;
            address_geo <= cmd_addr;
          end
        end
        RD: to_cnt <= 4'd0;
        WAIT: begin
          if (geo_rd_rdy_a) begin
            data_in_geo <= merge(data_out_geo, c_bit, c_bpp, c_color);
`ifdef GEO_PIXEL_RMW_COALESCE_EN
            idle_cnt    <= 8'd0;
`endif
          end else if (to_hit) begin
            err_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 4'd1;
          end
        end
        WR: begin
          if (!geo_port_full) begin
            pend <= 1'b0;
            if (pend) address_geo <= c_addr;
          end
        end
`ifdef GEO_PIXEL_RMW_COALESCE_EN
        HOLD: begin
          if (cmd_valid) begin
            idle_cnt <= 8'd0;
            if (same_addr) begin
              data_in_geo <= merge(data_in_geo, cmd_bit, cmd_bpp, cmd_color);
            end else begin
              c_addr  <= cmd_addr;
              c_bit   <= cmd_bit;
              c_bpp   <= cmd_bpp;
              c_color <= cmd_color;
              pend    <= 1'b1;
            end
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign cmd_ready    = ready;
  assign geo_rd_req_a = rd_req;
  assign geo_wr_ena   = wr_req;
  assign busy         = (st != IDLE);

endmodule

// File: tb/tb_geo_pixel_rmw.sv
// tb_geo_pixel_rmw: scoreboard bench for geo_pixel_rmw.
// A small mux model answers reads; a monitor checks every rd/wr pulse.
module tb_geo_pixel_rmw;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [19:0] cmd_addr;
  logic [3:0]  cmd_bit;
  logic [1:0]  cmd_bpp;
  logic [7:0]  cmd_color;
  logic        cmd_flush;
  logic        geo_rd_req_a;
  logic        geo_wr_ena;
  logic [19:0] address_geo;
  logic [15:0] data_in_geo;
  logic        geo_rd_rdy_a;
  logic [15:0] data_out_geo;
  logic        geo_port_full;
  logic        busy;
  logic        err_timeout;

  logic        rdy_m;
  logic        rdy_late;
  logic        mute;
  logic [15:0] rd_data;

  logic [19:0] rd_q[$];
  logic [35:0] wr_q[$];
  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  assign geo_rd_rdy_a = rdy_m | rdy_late;

  always #5 clk = ~clk;

  geo_pixel_rmw dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_bit      (cmd_bit),
    .cmd_bpp      (cmd_bpp),
    .cmd_color    (cmd_color),
    .cmd_flush    (cmd_flush),
    .geo_rd_req_a (geo_rd_req_a),
    .geo_wr_ena   (geo_wr_ena),
    .address_geo  (address_geo),
    .data_in_geo  (data_in_geo),
    .geo_rd_rdy_a (geo_rd_rdy_a),
    .data_out_geo (data_out_geo),
    .geo_port_full(geo_port_full),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  task automatic check(input string name, input logic [35:0] act,
                       input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mux model: one-cycle read latency after the request.
  initial begin
    rdy_m = 1'b0;
    data_out_geo = 16'd0;
    forever begin
      @(negedge clk);
      if (reset && geo_rd_req_a && !mute) begin
        @(posedge clk);
        #1;
        rdy_m = 1'b1;
        data_out_geo = rd_data;
        @(posedge clk);
        #1;
        rdy_m = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset && (geo_rd_req_a || geo_wr_ena)) begin
        check("excl", {35'd0, geo_rd_req_a & geo_wr_ena}, 36'd0);
        check("full_pulse", {35'd0, geo_port_full}, 36'd0);
        if (geo_rd_req_a) begin
          rd_cnt++;
          check("rd_expected", {35'd0, rd_q.size() != 0}, 36'd1);
          if (rd_q.size() != 0)
            check("rd_addr", {16'd0, address_geo}, {16'd0, rd_q.pop_front()});
        end
        if (geo_wr_ena) begin
          wr_cnt++;
          check("wr_expected", {35'd0, wr_q.size() != 0}, 36'd1);
          if (wr_q.size() != 0)
            check("wr_addr_data", {address_geo, data_in_geo}, wr_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] a, input logic [3:0] b,
                      input logic [1:0] p, input logic [7:0] c,
                      input logic f);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_bit   = b;
    cmd_bpp   = p;
    cmd_color = c;
    cmd_flush = f;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      cyc();
    end
    cmd_valid = 1'b0;
    cmd_flush = 1'b0;
    check("send_accept", {35'd0, ok}, 36'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready && !busy;
      cyc();
    end
    check("idle_reached", {35'd0, ok}, 36'd1);
  endtask

  task automatic wait_rd(input int n0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (rd_cnt > n0);
    end
    cyc();
    check("rd_seen", {35'd0, ok}, 36'd1);
  endtask

  initial begin
    int r0;
    int w0;
    int n;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = 20'd0;
    cmd_bit = 4'd0;
    cmd_bpp = 2'd0;
    cmd_color = 8'd0;
    cmd_flush = 1'b0;
    geo_port_full = 1'b0;
    rdy_late = 1'b0;
    mute = 1'b0;
    rd_data = 16'd0;
    repeat (3) cyc();
    reset = 1'b1;

    @(negedge clk);
    check("rst_ready", {35'd0, cmd_ready}, 36'd1);
    check("rst_busy", {35'd0, busy}, 36'd0);
    check("rst_rd", {35'd0, geo_rd_req_a}, 36'd0);
    check("rst_wr", {35'd0, geo_wr_ena}, 36'd0);
    check("rst_addr", {16'd0, address_geo}, 36'd0);
    check("rst_data", {20'd0, data_in_geo}, 36'd0);
    check("rst_err", {35'd0, err_timeout}, 36'd0);
    cyc();

    r0 = rd_cnt;
    w0 = wr_cnt;
    rd_data = 16'h1234;
    rd_q.push_back(20'h00100);
    wr_q.push_back({20'h00100, 16'h12A4});
    send(20'h00100, 4'd4, 2'd2, 8'h0A, 1'b0);
    wait_idle();
    check("t1_rd_count", 36'(rd_cnt - r0), 36'd1);
    check("t1_wr_count", 36'(wr_cnt - w0), 36'd1);

    rd_data = 16'h0000;
    rd_q.push_back(20'h00010);
    wr_q.push_back({20'h00010, 16'h8000});
    send(20'h00010, 4'd15, 2'd0, 8'h01, 1'b0);
    wait_idle();

    rd_data = 16'hFFFF;
    rd_q.push_back(20'h00020);
    wr_q.push_back({20'h00020, 16'h5CFF});
    send(20'h00020, 4'd9, 2'd3, 8'h5C, 1'b0);
    wait_idle();

    rd_data = 16'h0000;
    rd_q.push_back(20'h00030);
    wr_q.push_back({20'h00030, 16'h000C});
    send(20'h00030, 4'd3, 2'd1, 8'h07, 1'b0);
    wait_idle();

    r0 = rd_cnt;
    geo_port_full = 1'b1;
    rd_data = 16'h00FF;
    rd_q.push_back(20'h00300);
    wr_q.push_back({20'h00300, 16'h30FF});
    send(20'h00300, 4'd12, 2'd2, 8'h03, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("full_rd_addr", {16'd0, address_geo}, {16'd0, 20'h00300});
      check("full_rd_none", 36'(rd_cnt - r0), 36'd0);
      cyc();
    end
    geo_port_full = 1'b0;
    wait_idle();
    check("full_rd_count", 36'(rd_cnt - r0), 36'd1);

    r0 = rd_cnt;
    w0 = wr_cnt;
    rd_data = 16'hAAAA;
    rd_q.push_back(20'h00400);
    wr_q.push_back({20'h00400, 16'hAAAB});
    send(20'h00400, 4'd0, 2'd0, 8'h01, 1'b0);
    wait_rd(r0);
    geo_port_full = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("full_wr_none", 36'(wr_cnt - w0), 36'd0);
      cyc();
    end
    geo_port_full = 1'b0;
    wait_idle();
    check("full_wr_count", 36'(wr_cnt - w0), 36'd1);

    r0 = rd_cnt;
    w0 = wr_cnt;
    mute = 1'b1;
    rd_q.push_back(20'h00500);
    send(20'h00500, 4'd0, 2'd0, 8'h01, 1'b0);
    n = 0;
    for (int i = 0; i < 100 && rd_cnt == r0; i++) @(negedge clk);
    for (int i = 0; i < 40 && !err_timeout; i++) begin
      @(negedge clk);
      n++;
    end
    check("to_err", {35'd0, err_timeout}, 36'd1);
    check("to_clks", 36'(n), 36'(TO + 1));
    check("to_ready", {35'd0, cmd_ready}, 36'd1);
    cyc();
    wait_idle();
    check("to_no_wr", 36'(wr_cnt - w0), 36'd0);

    r0 = rd_cnt;
    w0 = wr_cnt;
    rd_q.push_back(20'h00600);
    send(20'h00600, 4'd0, 2'd0, 8'h01, 1'b0);
    wait_rd(r0);
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    rdy_late = 1'b1;
    cyc();
    rdy_late = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    check("mid_rst_no_wr", 36'(wr_cnt - w0), 36'd0);
    check("mid_rst_ready", {35'd0, cmd_ready}, 36'd1);
    check("mid_rst_busy", {35'd0, busy}, 36'd0);
    check("mid_rst_err", {35'd0, err_timeout}, 36'd0);
    check("mid_rst_addr", {16'd0, address_geo}, 36'd0);
    check("mid_rst_data", {20'd0, data_in_geo}, 36'd0);
    cyc();
    mute = 1'b0;

`ifdef GEO_PIXEL_RMW_COALESCE_EN
    r0 = rd_cnt;
    w0 = wr_cnt;
    rd_data = 16'h0000;
    rd_q.push_back(20'h00200);
    send(20'h00200, 4'd0, 2'd1, 8'h01, 1'b0);
    send(20'h00200, 4'd2, 2'd1, 8'h02, 1'b0);
    send(20'h00200, 4'd4, 2'd1, 8'h03, 1'b0);
    @(negedge clk);
    check("co_no_wr", 36'(wr_cnt - w0), 36'd0);
    check("co_hold_busy", {35'd0, busy}, 36'd1);
    cyc();
    wr_q.push_back({20'h00200, 16'h0039});
    send(20'h00200, 4'd0, 2'd1, 8'h01, 1'b1);
    wait_idle();
    check("co_rd_count", 36'(rd_cnt - r0), 36'd1);
    check("co_wr_count", 36'(wr_cnt - w0), 36'd1);
`endif

    repeat (5) cyc();
    check("rd_q_drained", 36'(rd_q.size()), 36'd0);
    check("wr_q_drained", 36'(wr_q.size()), 36'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
